// File: rtl/descrambler_rx_if.sv
// rtl/descrambler_rx_if.sv - serial bit stream into and out of the USB4 receive descrambler.
interface descrambler_rx_if #(
  parameter int ERR_W = 16
);
  logic             data_in;
  logic             enable;
  logic             descr_rst;
  logic             train;
  logic             data_out;
  logic             valid_out;
  logic             lock;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output data_in, enable, descr_rst, train,
    input  data_out, valid_out, lock, err_cnt
  );

  modport slave (
    input  data_in, enable, descr_rst, train,
    output data_out, valid_out, lock, err_cnt
  );
endinterface

// File: rtl/descrambler_rx.sv
// rtl/descrambler_rx.sv - USB4 23-bit LFSR descrambler with training lock FSM and error counting.
module descrambler_rx #(
  parameter logic [22:0] SEED       = 23'h1BBBBB,
  parameter int          LOCK_LEN   = 64,
  parameter int          WIN_LEN    = 256,
  parameter int          ERR_THRESH = 4,
  parameter int          ERR_W      = 16
) (
  input logic         clk,
  input logic         rst,
  descrambler_rx_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int WC_W = $clog2(WIN_LEN + 1);
  localparam int WE_W = $clog2(ERR_THRESH + 1);
  localparam logic [7:0]      LOCK_V = 8'(LOCK_LEN);
  localparam logic [WC_W-1:0] WIN_V  = WC_W'(WIN_LEN);
  localparam logic [WE_W-1:0] THR_V  = WE_W'(ERR_THRESH);

  logic [22:0]      s;
  logic [1:0]       state;
  logic [7:0]       run;
  logic [WC_W-1:0]  win_cnt;
  logic [WE_W-1:0]  win_err;
  logic [ERR_W-1:0] err_q;
  logic             data_q;
  logic             valid_q;
  logic             lock_q;

  logic             k;
  logic             e;
  logic [22:0]      s_next;
  logic [7:0]       run_next;
  logic [WC_W-1:0]  wc_next;
  logic [WE_W-1:0]  we_next;

  always_comb begin
    k        = s[22];
    e        = bus.data_in ^ k;
    s_next   = {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
    // run is zero in IDLE, so the first training bit lands on 0 or 1 as a CHECK bit
    run_next = e ? 8'd0 : ((run == 8'hFF) ? run : run + 8'd1);
    wc_next  = win_cnt + 1'b1;
    we_next  = win_err + {{(WE_W-1){1'b0}}, e};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s       <= SEED;
      state   <= IDLE;
      run     <= '0;
      win_cnt <= '0;
      win_err <= '0;
      err_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else if (bus.descr_rst) begin
      s       <= SEED;
      state   <= IDLE;
      run     <= '0;
      win_cnt <= '0;
      win_err <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else if (bus.enable) begin
      s       <= s_next;
      data_q  <= e;
      valid_q <= 1'b1;
      if (bus.train) begin
        if (e && (err_q != '1)) err_q <= err_q + 1'b1;
        if (state == LOCKED) begin
          // threshold is checked before the window closes, so a closing-bit error counts here
          if (we_next == THR_V) begin
            state   <= CHECK;
            lock_q  <= 1'b0;
            run     <= '0;
            win_cnt <= '0;
            win_err <= '0;
          end else if (wc_next == WIN_V) begin
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            win_cnt <= wc_next;
            win_err <= we_next;
          end
        end else begin
          run <= run_next;
          if (run_next == LOCK_V) begin
            state   <= LOCKED;
            lock_q  <= 1'b1;
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            state <= CHECK;
          end
        end
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.lock      = lock_q;
  assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_descrambler_rx.sv
// tb/tb_descrambler_rx.sv - scoreboard bench for descrambler_rx fed by a golden transmit scrambler.
module tb_descrambler_rx;
  localparam logic [22:0] SEED = 23'h1BBBBB;

  typedef struct {
    int n;
    int flip;
    int exp_lock;
    int exp_err;
  } lock_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [22:0] tx_s = SEED;
  logic exp_q[$];
  int flips[$];
  int checks = 0;
  int failures = 0;
  lock_vec_t vecs[5];

  descrambler_rx_if #(.ERR_W(16)) bus();

  descrambler_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] lfsr_next(input logic [22:0] v);
    return {v[21:0], v[22] ^ v[20] ^ v[15] ^ v[7] ^ v[4] ^ v[1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, let the edge happen, then compare 1 ns later against the scoreboard.
  task automatic step(input logic en, input logic p, input logic tr, input logic dr);
    logic pending;
    logic expd;
    bus.enable    = en;
    bus.train     = tr;
    bus.descr_rst = dr;
    pending = en && !dr;
    if (pending) begin
      bus.data_in = p ^ tx_s[22];
      exp_q.push_back(p);
    end else begin
      bus.data_in = 1'($urandom);
    end
    @(posedge clk);
    if (dr) tx_s = SEED;
    else if (en) tx_s = lfsr_next(tx_s);
    #1;
    chk("valid_out", 32'(bus.valid_out), 32'(pending));
    if (pending) begin
      expd = exp_q.pop_front();
      chk("data_out", 32'(bus.data_out), 32'(expd));
    end
  endtask

  task automatic run_train(input int n, output int first_lock, output int first_unlock);
    logic p;
    first_lock = 0;
    first_unlock = 0;
    for (int i = 1; i <= n; i++) begin
      p = 1'b0;
      foreach (flips[j]) if (flips[j] == i) p = 1'b1;
      step(1'b1, p, 1'b1, 1'b0);
      if (bus.lock && first_lock == 0) first_lock = i;
      if (!bus.lock && first_unlock == 0) first_unlock = i;
    end
  endtask

  task automatic reseed_and_lock();
    int fl;
    int fu;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    flips = {};
    run_train(64, fl, fu);
    chk("relock_at_64", 32'(fl), 32'd64);
  endtask

  initial begin
    int fl;
    int fu;
    vecs[0] = '{n: 64,  flip: 0,  exp_lock: 64,  exp_err: 0};
    vecs[1] = '{n: 63,  flip: 0,  exp_lock: 0,   exp_err: 0};
    vecs[2] = '{n: 104, flip: 40, exp_lock: 104, exp_err: 1};
    vecs[3] = '{n: 128, flip: 64, exp_lock: 128, exp_err: 1};
    vecs[4] = '{n: 65,  flip: 1,  exp_lock: 65,  exp_err: 1};

    bus.data_in = 1'b0;
    bus.enable = 1'b0;
    bus.descr_rst = 1'b0;
    bus.train = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_lock", 32'(bus.lock), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Loopback with random payload, enable always high
    for (int i = 0; i < 1000; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    chk("loopback_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Random enable gaps; the keystream must only move on enabled bits
    for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)), 1'($urandom), 1'b0, 1'b0);

    // Lock acquisition table
    foreach (vecs[v]) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("reseed_lock", 32'(bus.lock), 32'd0);
      flips = {};
      if (vecs[v].flip != 0) flips.push_back(vecs[v].flip);
      run_train(vecs[v].n, fl, fu);
      chk($sformatf("lock_at_v%0d", v), 32'(fl), 32'(vecs[v].exp_lock));
      chk($sformatf("err_v%0d", v), 32'(bus.err_cnt), 32'(vecs[v].exp_err));
    end

    // Loss of lock: 4 errors in one window, lock drops on the 4th
    reseed_and_lock();
    flips = {10, 50, 100, 200};
    run_train(200, fl, fu);
    chk("lol_locked_before", 32'(fl), 32'd1);
    chk("lol_unlock_at", 32'(fu), 32'd200);
    chk("lol_err_cnt", 32'(bus.err_cnt), 32'd4);

    // 3 errors per window for 3 windows, including each window's closing bit
    reseed_and_lock();
    flips = {5, 100, 256, 261, 356, 512, 517, 612, 768};
    run_train(768, fl, fu);
    chk("win3_never_unlock", 32'(fu), 32'd0);
    chk("win3_err_cnt", 32'(bus.err_cnt), 32'd9);

    // descr_rst while locked with errors outstanding
    reseed_and_lock();
    flips = {3, 4, 5, 300, 301};
    run_train(320, fl, fu);
    chk("pre_drst_lock", 32'(bus.lock), 32'd1);
    chk("pre_drst_err", 32'(bus.err_cnt), 32'd5);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("drst_lock", 32'(bus.lock), 32'd0);
    chk("drst_err", 32'(bus.err_cnt), 32'd0);
    bus.enable = 1'b1;
    bus.train = 1'b0;
    bus.descr_rst = 1'b0;
    bus.data_in = 1'b1;
    @(posedge clk);
    tx_s = lfsr_next(tx_s);
    #1;
    chk("first_k_after_reseed", 32'(bus.data_out), 32'd1);
    chk("first_k_valid", 32'(bus.valid_out), 32'd1);

    // Async reset between edges
    flips = {1};
    run_train(10, fl, fu);
    chk("pre_rst_err", 32'(bus.err_cnt), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_data_out", 32'(bus.data_out), 32'd0);
    chk("async_valid_out", 32'(bus.valid_out), 32'd0);
    chk("async_lock", 32'(bus.lock), 32'd0);
    chk("async_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tx_s = SEED;
    exp_q = {};
    for (int i = 0; i < 200; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    flips = {};
    run_train(64, fl, fu);
    chk("post_rst_lock_at", 32'(fl), 32'd64);
    chk("post_rst_err", 32'(bus.err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
